uart_tx_feeder: RTL and testbench

Byte buffer and launch controller that sits directly upstream of the UART transmitter, in the `tx_clk` domain. It accepts bytes from system logic through a valid/ready write port and stores them in a DEPTH-entry FIFO. It launches them one at a time into the transmitter through its `en`/`data_in`/`done` interface. It holds each byte stable for the whole frame and recovers, via a watchdog, if `done` never returns.

---
 rtl/uart_tx_feeder.sv | 149 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
// Byte buffer and launch controller that sits directly upstream of the UART
// transmitter in the tx_clk domain. System logic writes bytes through a
// valid/ready port into a DEPTH-entry circular FIFO. A two-state controller
// launches each byte into the transmitter with a one-cycle en pulse. It holds
// the byte on tx_data until the next launch. A watchdog aborts a frame whose
// done never comes back.
//
// Ports:
//   tx_clk    in   clock, rising edge
//   rst       in   asynchronous, active-high reset
//   wr_data   in   [7:0] byte to enqueue
//   wr_valid  in   write request
//   wr_ready  out  high while the FIFO is not full
//   tx_en     out  registered one-cycle launch pulse to the transmitter
//   tx_data   out  [7:0] registered byte to the transmitter, held per frame
//   tx_done   in   transmitter end-of-frame pulse
//   tx_err    out  registered one-cycle pulse on watchdog abort
//   level     out  [$clog2(DEPTH):0] bytes currently stored
//   active    out  high while a frame is in flight or bytes are queued
//
// DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.
// TIMEOUT must be >= 12 so that a healthy frame always finishes first.
module uart_tx_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 31
) (
  input  logic                     tx_clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic                     tx_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     active
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WW-1:0]   wd_cnt_q;
  logic [WW-1:0]   wd_cnt_d;
  logic            tx_en_d;
  logic [7:0]      tx_data_d;
  logic            tx_err_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Full is decoded from the registered level, so wr_ready never depends on
  // wr_valid or on the pop in the same cycle.
  assign wr_ready = (level != LW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign active   = (state_q != IDLE) || (level != '0);

  // Storage array has no reset; its contents are only meaningful between
  // the pointers, which are reset.
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap at DEPTH by overflow. A simultaneous push and pop moves
  // both pointers and leaves level alone.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Launch controller. The pop happens only on the IDLE->WAIT step, and it
  // sees the registered level, so a byte written into an empty FIFO launches
  // one cycle later (no bypass). In WAIT, done wins over an expiry that falls
  // in the same cycle. An expired frame is dropped, not retried.
  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data;
    tx_err_d  = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (level != '0) begin
          pop       = 1'b1;
          tx_data_d = mem[rd_ptr];
          tx_en_d   = 1'b1;
          wd_cnt_d  = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + WW'(1);
        if (tx_done) begin
          state_d = IDLE;
        end else if (wd_cnt_q == WW'(TIMEOUT - 1)) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wd_cnt_q <= '0;
      tx_en    <= 1'b0;
      tx_data  <= 8'h00;
      tx_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      tx_en    <= tx_en_d;
      tx_data  <= tx_data_d;
      tx_err   <= tx_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
// Self-checking bench for uart_tx_feeder. It pairs the feeder with a
// behavioural transmitter that can run normally, stay stuck, or return done
// after a chosen delay. A negedge monitor keeps a scoreboard of accepted
// bytes, an occupancy model and the watchdog deadline. A vector table drives
// the multi-write sequences. Hand-written sequences cover reset, watchdog
// and FIFO wrap.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 31;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          tx_clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          tx_en;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          tx_err;
  logic [LW-1:0] level;
  logic          active;

  always #5 tx_clk = ~tx_clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .tx_clk   (tx_clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .tx_err   (tx_err),
    .level    (level),
    .active   (active)
  );

  // Transmitter model. It samples en at the end of the en cycle. frame_cnt
  // is k in the k-th cycle after the en cycle: 1 is START, 2..9 are DATA
  // (LSB first), 10 is STOP. done comes when frame_cnt equals done_delay
  // (11 for a healthy frame).
  logic       stuck;
  int         done_delay;
  logic [7:0] frame_cnt;
  logic [7:0] frame_byte;
  logic       serial;

  always @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      frame_cnt  <= 8'd0;
      frame_byte <= 8'h00;
    end else if (tx_en) begin
      frame_cnt  <= 8'd1;
      frame_byte <= tx_data;
    end else if (frame_cnt != 8'd0) begin
      if (!stuck && frame_cnt == 8'(done_delay))
        frame_cnt <= 8'd0;
      else if (frame_cnt != 8'hFF)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign tx_done = !stuck && (frame_cnt != 8'd0) && (frame_cnt == 8'(done_delay));

  always_comb begin
    serial = 1'b1;
    if (frame_cnt == 8'd1)
      serial = 1'b0;
    else if (frame_cnt >= 8'd2 && frame_cnt <= 8'd9)
      serial = frame_byte[3'(frame_cnt - 8'd2)];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  int         en_log[$];
  int         err_log[$];
  int         cyc = 0;
  int         m_level;
  logic       acc_prev;
  logic       in_flight;
  int         en_cyc;
  logic [7:0] last_data;
  logic [7:0] exp_byte;
  logic       exp_err;
  logic       prev_en;
  int         en_count = 0;
  int         err_count = 0;
  int         done_count = 0;
  logic [9:0] ser_cap;

  // Monitor: samples mid-cycle, away from the active edge. A launch seen
  // in cycle c means a pop at the edge that opened c. A write seen in cycle
  // c is stored at the edge that closes it, if the model says the FIFO is
  // not full.
  always @(negedge tx_clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_level   = 0;
      acc_prev  = 1'b0;
      in_flight = 1'b0;
      last_data = 8'h00;
      prev_en   = 1'b0;
    end else begin
      if (tx_en) begin
        if (prev_en) checkOutput("tx_en_one_cycle", 32'(tx_en), 32'(0));
        if (exp_q.size() == 0) begin
          checkOutput("tx_en_with_nothing_queued", 32'(tx_en), 32'(0));
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("tx_data_order", 32'(tx_data), 32'(exp_byte));
          last_data = exp_byte;
        end
        en_count++;
        en_log.push_back(cyc);
      end else begin
        checkOutput("tx_data_held", 32'(tx_data), 32'(last_data));
      end

      m_level = m_level + (acc_prev ? 1 : 0) - (tx_en ? 1 : 0);
      checkOutput("level", 32'(level), 32'(m_level));
      checkOutput("wr_ready", 32'(wr_ready), 32'(m_level < DEPTH));

      // The abort pulse lands TIMEOUT cycles after the en cycle, unless done
      // came back during the WAIT (including the expiry cycle itself).
      exp_err = in_flight && (cyc == en_cyc + TIMEOUT);
      checkOutput("tx_err", 32'(tx_err), 32'(exp_err));
      if (tx_err) begin
        err_count++;
        err_log.push_back(cyc);
      end
      if (exp_err) in_flight = 1'b0;
      if (tx_en) begin
        in_flight = 1'b1;
        en_cyc    = cyc;
      end
      if (tx_done) begin
        done_count++;
        in_flight = 1'b0;
      end

      acc_prev = wr_valid && (m_level < DEPTH);
      if (acc_prev) exp_q.push_back(wr_data);
      prev_en = tx_en;

      if (frame_cnt >= 8'd1 && frame_cnt <= 8'd10)
        ser_cap[4'(frame_cnt - 8'd1)] = serial;
    end
  end

  // Vector table: a write (or idle) for one cycle, and the level expected in
  // the following cycle.
  typedef struct {
    logic       valid;
    logic [7:0] data;
    int         exp_level;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input int l);
    vec_t r;
    r.valid     = v;
    r.data      = d;
    r.exp_level = l;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    wr_valid = v;
    wr_data  = d;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tx_clk);
      #1;
    end
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data);
      tick(1);
      checkOutput($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
    end
    applyStimulus(1'b0, 8'h00);
  endtask

  int base_en;
  int base_err;
  int base_done;

  initial begin
    // Back-to-back from empty and idle: the first byte pops in the cycle
    // after it lands, while the second arrives, so level reads 1,1,2.
    vecs[0] = mk(1'b1, 8'h01, 1);
    vecs[1] = mk(1'b1, 8'h02, 1);
    vecs[2] = mk(1'b1, 8'h03, 2);
    vecs[3] = mk(1'b0, 8'h00, 2);
    // Build level 4, then write C5 in the IDLE cycle after C0's done, so the
    // push lands on the same edge as C1's pop.
    vecs[4] = mk(1'b1, 8'hC0, 1);
    vecs[5] = mk(1'b1, 8'hC1, 1);
    vecs[6] = mk(1'b1, 8'hC2, 2);
    vecs[7] = mk(1'b1, 8'hC3, 3);
    vecs[8] = mk(1'b1, 8'hC4, 4);
    for (int i = 9; i <= 17; i++) vecs[i] = mk(1'b0, 8'h00, 4);
    vecs[18] = mk(1'b1, 8'hC5, 4);
    vecs[19] = mk(1'b0, 8'h00, 4);

    rst        = 1'b1;
    stuck      = 1'b0;
    done_delay = 11;
    applyStimulus(1'b0, 8'h00);
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single byte through a healthy transmitter
    $display("[TB] single byte A5");
    base_en   = en_count;
    base_done = done_count;
    ser_cap   = 10'h000;
    applyStimulus(1'b1, 8'hA5);
    tick(1);
    applyStimulus(1'b0, 8'h00);
    tick(16);
    checkOutput("a5_en_pulses", 32'(en_count - base_en), 32'(1));
    checkOutput("a5_done_seen", 32'(done_count - base_done), 32'(1));
    // start 0, data 1,0,1,0,0,1,0,1, stop 1 (bit i = i-th line value)
    checkOutput("a5_serial_line", 32'(ser_cap), 32'(10'b1101001010));
    checkOutput("a5_level_after", 32'(level), 32'(0));
    checkOutput("a5_active_after", 32'(active), 32'(0));

    // Back-to-back launches are 13 cycles apart
    $display("[TB] back-to-back 01 02 03");
    en_log.delete();
    run_vectors(0, 3);
    tick(40);
    checkOutput("b2b_launches", 32'(en_log.size()), 32'(3));
    if (en_log.size() >= 3) begin
      checkOutput("b2b_gap_1", 32'(en_log[1] - en_log[0]), 32'(13));
      checkOutput("b2b_gap_2", 32'(en_log[2] - en_log[1]), 32'(13));
    end

    // Simultaneous push and pop
    $display("[TB] push on launch edge");
    en_log.delete();
    run_vectors(4, 19);
    tick(90);
    checkOutput("pp_launches", 32'(en_log.size()), 32'(6));
    checkOutput("pp_level_after", 32'(level), 32'(0));

    // Watchdog with a transmitter that never answers
    $display("[TB] watchdog");
    stuck = 1'b1;
    en_log.delete();
    err_log.delete();
    applyStimulus(1'b1, 8'hB0);
    tick(1);
    applyStimulus(1'b1, 8'hB1);
    tick(1);
    applyStimulus(1'b0, 8'h00);
    tick(80);
    checkOutput("wd_err_pulses", 32'(err_log.size()), 32'(2));
    checkOutput("wd_launches", 32'(en_log.size()), 32'(2));
    if (err_log.size() >= 1 && en_log.size() >= 2) begin
      checkOutput("wd_err_delay", 32'(err_log[0] - en_log[0]), 32'(TIMEOUT));
      // relaunch comes 2 cycles after the expiry cycle, 1 after the pulse
      checkOutput("wd_relaunch", 32'(en_log[1] - en_log[0]), 32'(TIMEOUT + 1));
    end
    stuck = 1'b0;

    // done arriving exactly in the expiry cycle suppresses the abort
    $display("[TB] done on expiry cycle");
    done_delay = TIMEOUT - 1;
    base_err   = err_count;
    base_done  = done_count;
    applyStimulus(1'b1, 8'hD0);
    tick(1);
    applyStimulus(1'b0, 8'h00);
    tick(50);
    checkOutput("late_done_no_err", 32'(err_count - base_err), 32'(0));
    checkOutput("late_done_seen", 32'(done_count - base_done), 32'(1));
    done_delay = 11;

    // Fill past full with a stuck transmitter, then drain across the wrap
    $display("[TB] full and wrap");
    stuck = 1'b1;
    en_log.delete();
    err_log.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h10 + 8'(i));
      tick(1);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("full_level", 32'(level), 32'(16));
    checkOutput("full_wr_ready", 32'(wr_ready), 32'(0));
    stuck = 1'b0;
    tick(240);
    checkOutput("wrap_launches", 32'(en_log.size()), 32'(17));
    checkOutput("wrap_aborts", 32'(err_log.size()), 32'(1));
    checkOutput("wrap_level_after", 32'(level), 32'(0));
    checkOutput("wrap_all_emitted", 32'(exp_q.size()), 32'(0));

    // Asynchronous reset mid-frame, between clock edges
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'hE0);
    tick(1);
    applyStimulus(1'b1, 8'hE1);
    tick(1);
    applyStimulus(1'b1, 8'hE2);
    tick(1);
    applyStimulus(1'b0, 8'h00);
    tick(3);
    @(posedge tx_clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst_tx_en", 32'(tx_en), 32'(0));
    checkOutput("rst_tx_data", 32'(tx_data), 32'(8'h00));
    checkOutput("rst_tx_err", 32'(tx_err), 32'(0));
    checkOutput("rst_level", 32'(level), 32'(0));
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'(1));
    checkOutput("rst_active", 32'(active), 32'(0));
    tick(2);
    rst = 1'b0;
    base_en = en_count;
    tick(50);
    checkOutput("post_rst_no_launch", 32'(en_count - base_en), 32'(0));
    checkOutput("post_rst_active", 32'(active), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
